// File: rtl/ram_bus_master.sv
// ram_bus_master: 4-bit RAM bus initiator issuing optional SRC then one I/O instruction cycle per request
module ram_bus_master (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] data_i,
  output logic [3:0] data_o,
  output logic       data_en,
  output logic       sync,
  output logic       cmd_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_src,
  input  logic [1:0] req_chip,
  input  logic [1:0] req_reg,
  input  logic [3:0] req_char,
  input  logic [3:0] req_op,
  input  logic [3:0] req_wdata,
  output logic       rsp_valid,
  output logic [3:0] rsp_data,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, SRC, IO} state_t;
  state_t state, state_n;
  logic [2:0] phase, phase_n;
  logic [1:0] cur_chip, cur_reg;
  logic [3:0] cur_char, cur_op, cur_wdata, d_n;
  logic accept, rd, wr, en_n, cmd_n_n;
  assign phase_n = phase + 3'd1;
  assign req_ready = phase == 3'd7 && state != SRC;
  assign accept = req_ready && req_valid;
  assign busy = state != IDLE;
  assign rd = cur_op[3] && cur_op != 4'hA;
  assign wr = !cur_op[3] && cur_op[3:1] != 3'b001;
  // Outputs are decoded for the phase about to start, so registering them aligns them with it.
  always_comb begin
    state_n = phase != 3'd7 ? state : accept ? (req_src ? SRC : IO) : state == SRC ? IO : IDLE;
    d_n = 4'h0;
    en_n = 1'b0;
    cmd_n_n = 1'b1;
    if (state_n == SRC)
      case (phase_n)
        3'd3: begin d_n = 4'h2; en_n = 1'b1; end
        3'd4: begin d_n = 4'h1; en_n = 1'b1; end
        3'd5: en_n = 1'b0;
        3'd6: begin d_n = {cur_chip, cur_reg}; en_n = 1'b1; cmd_n_n = 1'b0; end
        3'd7: begin d_n = cur_char; en_n = 1'b1; end
        default: en_n = 1'b1;
      endcase
    else if (state_n == IO)
      case (phase_n)
        3'd3: begin d_n = 4'hE; en_n = 1'b1; end
        3'd4: begin d_n = cur_op; en_n = 1'b1; cmd_n_n = 1'b0; end
        3'd5, 3'd7: en_n = 1'b0;
        3'd6: begin d_n = wr ? cur_wdata : 4'h0; en_n = wr; end
        default: en_n = 1'b1;
      endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      phase <= 3'd0;
      data_o <= 4'h0;
      data_en <= 1'b0;
      cmd_n <= 1'b1;
      sync <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data <= 4'h0;
      cur_chip <= 2'd0;
      cur_reg <= 2'd0;
      cur_char <= 4'h0;
      cur_op <= 4'h0;
      cur_wdata <= 4'h0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      data_o <= d_n;
      data_en <= en_n;
      cmd_n <= cmd_n_n;
      sync <= phase_n == 3'd7;
      rsp_valid <= state == IO && phase == 3'd6;
      if (state == IO && phase == 3'd6)
        rsp_data <= rd ? data_i : 4'h0;
      if (accept) begin
        cur_chip <= req_chip;
        cur_reg <= req_reg;
        cur_char <= req_char;
        cur_op <= req_op;
        cur_wdata <= req_wdata;
      end
    end
endmodule

// File: doc/ram_bus_master.md
# ram_bus_master

Bus initiator for the 4-bit instruction-cycle RAM bus: the opposite end of the RAM chips' responder logic. Takes single RAM/status/output-port requests over a valid/ready handshake and emits the 8-phase bus cycles a RAM chip decodes: an optional SRC cycle, then one I/O instruction cycle. Returns read data on a response strobe. Used as the bus master in RAM-subsystem test tops and by debug/bring-up logic that needs RAM access without the CPU core.

## Interface
Parameters:
- none

Ports:
- `clock` in 1: system clock, one bus phase per cycle
- `reset` in 1: asynchronous, active-high; all state and outputs to reset values immediately
- `data_i` in 4: bus value driven by RAM chips
- `data_o` out 4: bus value driven by master; reset 0
- `data_en` out 1: master drives bus; reset 0; external tristate at top level
- `sync` out 1: high during phase 7 only; reset 0
- `cmd_n` out 1: active-low command strobe; reset 1
- `req_valid` in 1: request present
- `req_ready` out 1: request accepted this clock when `req_valid` also high; reset 0
- `req_src` in 1: 1 = issue SRC cycle before the I/O cycle; 0 = reuse the current chip selection
- `req_chip` in 2: chip select, sent as SRC `data[3:2]` = {chip id bit, p0}
- `req_reg` in 2: register address, sent as SRC `data[1:0]`
- `req_char` in 4: character address, sent at SRC phase 7
- `req_op` in 4: I/O subcode (low nibble of `Ex` opcode)
- `req_wdata` in 4: write data
- `rsp_valid` out 1: one-clock pulse when a request completes; reset 0
- `rsp_data` out 4: captured read data, valid with `rsp_valid`; reset 0
- `busy` out 1: state != IDLE; reset 0

## Operation
- Phase counter: 3 bits, reset 0, free-running 0→7→0. It is phase-aligned with the RAM chips' cycle counters because all share `reset`.
- States: IDLE, SRC, IO.
- Acceptance: `req_ready` = (phase==7) && (state==IDLE || state==IO). On acceptance, register all `req_*` fields. The next state is SRC if `req_src` is set, else IO.
- SRC completes after its phase 7 and goes to IO.
- IO completes after its phase 7 and goes to IDLE, unless a new request is accepted in that same clock. This gives back-to-back cycles with no gap.
- IDLE cycles: `cmd_n`=1, `data_en`=0.
- SRC cycle, per phase:
  - phases 0–2: drive 0.
  - phase 3: drive 4'h2.
  - phase 4: drive {req_reg[1]... no shared field: 4'h1}, i.e. drive 4'h1.
  - phase 5: `data_en`=0.
  - phase 6: drive {chip,reg} with `cmd_n`=0.
  - phase 7: drive `req_char` with `cmd_n`=1.
- IO cycle, per phase:
  - phases 0–2: drive 0.
  - phase 3: drive 4'hE.
  - phase 4: drive `req_op` with `cmd_n`=0.
  - phase 5: `data_en`=0.
  - phase 6: behaviour depends on the op class (below).
  - phase 7: `data_en`=0.
- Op classes:
  - Write ops 0, 1, 4–7: drive `req_wdata` at phase 6.
  - Read ops 8, 9, B, C–F: `data_en`=0 at phase 6; capture `data_i` at the phase-6 clock edge.
  - Ops 2, 3, A: no bus drive at phase 6; `rsp_data`=0.
- Response: `rsp_valid` is high during IO phase 7. `rsp_data` is the captured value for reads and 0 otherwise. It holds until the next response.
- `cmd_n` is low only at SRC phase 6 and IO phase 4.
- Request fields need not be held after acceptance.

## Timing
- Outputs (`data_o`, `data_en`, `cmd_n`, `sync`, `rsp_*`) are registered.
- "Phase N" denotes the clock in which the phase counter reads N. Outputs are registered from the next-phase decode so they are valid during that phase.
- Latency, acceptance to `rsp_valid`: 8 clocks without SRC, 16 clocks with SRC.
- Throughput: one request per 8 clocks with `req_src`=0; one per 16 clocks with `req_src`=1.
- Reset mid-operation:
  - Immediate abort and return to IDLE.
  - Phase counter returns to 0.
  - No `rsp_valid` is issued for the aborted request.
  - A RAM chip's partially latched SRC selection may persist, so the first request after reset must use `req_src`=1.
- `req_valid` outside phase 7 is ignored: `req_ready` stays 0 and nothing is accepted.

## Test plan
- **Reset:** release reset, observe 16 clocks.
  - Expect `sync` high only at phases 7 and 15.
  - Expect `cmd_n`=1, `data_en`=0, `busy`=0, and `req_ready` high only at phase 7.
- **WRM with SRC** (RAM model CHIP_ID=0, p0=0 attached): op 0, chip 0, reg 2, char 5, wdata A.
  - SRC phase 6: `data_o`=2, `cmd_n`=0. SRC phase 7: `data_o`=5.
  - IO phase 4: `data_o`=0, `cmd_n`=0. IO phase 6: `data_o`=A, `data_en`=1.
  - `rsp_valid` asserted 16 clocks after acceptance. RAM memory[37]=A.
- **Back-to-back RDM:** op 9, src=0, accepted in the previous IO phase 7.
  - No idle cycle between the two requests.
  - Phase 6: `data_en`=0.
  - `rsp_data`=A, with `rsp_valid` 8 clocks after acceptance.
- **Status write/read:** WR2 (op 6, wdata 7), then RD2 (op E).
  - `rsp_data`=7; RAM status[10]=7.
- **Output port:** WMP (op 1, wdata C).
  - RAM `out`=C after IO phase 6; `rsp_data`=0.
- **Reset mid-cycle:** assert reset at IO phase 5 of a read.
  - `data_en`=0 and `cmd_n`=1 immediately.
  - No `rsp_valid`; phase counter 0 after release.
